// File: rtl/fft_output_reader_if.sv
// ---------------------------------------------------------------------------
// fft_output_reader_if
//   Bundles the control, RAM read and streaming output signals of
//   fft_output_reader.
//   slave  : the reader itself (drives busy/done, the RAM read strobe and
//            the output stream; receives start, rd_data, out_ready)
//   master : the environment (drives start, RAM data and out_ready)
//   Signals: start, busy, done, rd_en, rd_addr[MSB], rd_data[DW],
//            out_data[DW], out_index[MSB], out_valid, out_ready, out_last
// ---------------------------------------------------------------------------
interface fft_output_reader_if #(
    parameter int MSB = 8,
    parameter int DW  = 32
);
    logic           start;
    logic           busy;
    logic           done;
    logic           rd_en;
    logic [MSB-1:0] rd_addr;
    logic [DW-1:0]  rd_data;
    logic [DW-1:0]  out_data;
    logic [MSB-1:0] out_index;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;

    modport master (
        output start, rd_data, out_ready,
        input  busy, done, rd_en, rd_addr, out_data, out_index, out_valid, out_last
    );

    modport slave (
        input  start, rd_data, out_ready,
        output busy, done, rd_en, rd_addr, out_data, out_index, out_valid, out_last
    );
endinterface

// File: rtl/fft_output_reader.sv
// ---------------------------------------------------------------------------
// fft_output_reader
//   Walks the in-place FFT result RAM in bit-reversed address order so the
//   spectrum leaves in natural bin order 0..N-1 over a valid/ready stream.
//   A 2-entry buffer absorbs the RAM's one-cycle read latency; reads are
//   only issued when a buffer slot is guaranteed for the returning data.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset, aborts any read-out
//     bus   : fft_output_reader_if.slave (start/busy/done, RAM read port,
//             output stream with natural index and last-bin flag)
// ---------------------------------------------------------------------------
module fft_output_reader #(
    parameter int MSB = 8,
    parameter int DW  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fft_output_reader_if.slave   bus
);
    localparam int N = 1 << MSB;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [MSB-1:0] index;
        logic           last;
    } entry_t;

    state_t         state_q, state_d;
    logic [MSB:0]   k_q, k_d;            // issue counter
    logic           inflight_q, inflight_d;
    logic [MSB-1:0] tag_index_q, tag_index_d;
    logic           tag_last_q, tag_last_d;
    entry_t         buf0_q, buf0_d;      // head entry
    entry_t         buf1_q, buf1_d;
    logic [1:0]     occ_q, occ_d;
    logic           done_q, done_d;

    logic           pop, push, rd_en;
    logic [2:0]     level;
    logic [MSB-1:0] rd_addr;
    entry_t         new_entry;

    // Buffer slots that will be committed once this cycle's pop and the
    // in-flight return settle; a new read is safe only if one is left free.
    assign pop   = (occ_q != 2'd0) && bus.out_ready;
    assign push  = inflight_q;
    assign level = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    assign rd_en = (state_q == READ) && (level <= 3'd1);

    assign new_entry = '{data: bus.rd_data, index: tag_index_q, last: tag_last_q};

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        rd_addr = '0;
        for (int i = 0; i < MSB; i++) begin
            rd_addr[i] = k_q[MSB-1-i];
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        done_d      = 1'b0;
        inflight_d  = rd_en;
        tag_index_d = tag_index_q;
        tag_last_d  = tag_last_q;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = READ;
                    k_d     = '0;
                end
            end
            READ: begin
                if (rd_en) begin
                    k_d = k_q + (MSB+1)'(1);
                    if (k_q == (MSB+1)'(N-1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && buf0_q.last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Tag travels alongside the read so it meets its data next cycle.
        if (rd_en) begin
            tag_index_d = k_q[MSB-1:0];
            tag_last_d  = (k_q == (MSB+1)'(N-1));
        end

        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) buf0_d = new_entry;
                else               buf1_d = new_entry;
            end
            2'b01: buf0_d = buf1_q;
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = new_entry;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = new_entry;
                end
            end
            default: ;
        endcase

        occ_d = occ_q + 2'(push) - 2'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            inflight_q  <= 1'b0;
            tag_index_q <= '0;
            tag_last_q  <= 1'b0;
            // NOTE: the buffer entries are reset (not just the occupancy)
            // because the head drives out_data/out_index, which must read 0.
            buf0_q      <= '0;
            buf1_q      <= '0;
            occ_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            inflight_q  <= inflight_d;
            tag_index_q <= tag_index_d;
            tag_last_q  <= tag_last_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            occ_q       <= occ_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr   = rd_addr;
    assign bus.out_valid = (occ_q != 2'd0);
    assign bus.out_data  = buf0_q.data;
    assign bus.out_index = buf0_q.index;
    // The head keeps its last value after draining; gate so out_last only
    // accompanies a valid bin.
    assign bus.out_last  = (occ_q != 2'd0) && buf0_q.last;
endmodule

// File: tb/tb_fft_output_reader.sv
module tb_fft_output_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_output_reader_if #(.MSB(3), .DW(32)) ifa ();
    fft_output_reader_if #(.MSB(4), .DW(32)) ifb ();

    fft_output_reader #(.MSB(3), .DW(32)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    fft_output_reader #(.MSB(4), .DW(32)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    // RAM models: RAM[a] = a*16, one-cycle read latency
    always @(posedge clk) begin
        if (ifa.rd_en) ifa.rd_data <= 32'(ifa.rd_addr) * 32'd16;
        if (ifb.rd_en) ifb.rd_data <= 32'(ifb.rd_addr) * 32'd16;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int bitrev(input int v, input int w);
        int r = 0;
        for (int i = 0; i < w; i++) if (v & (1 << i)) r |= 1 << (w - 1 - i);
        return r;
    endfunction

    typedef struct {
        logic        busy, rd_en;
        logic [2:0]  rd_addr;
        logic        valid;
        logic [2:0]  idx;
        logic [31:0] data;
        logic        last, done;
    } row_t;

    row_t tbl[1:12];

    function automatic row_t mk(input logic busy, input logic rd_en, input logic [2:0] addr,
                                input logic valid, input logic [2:0] idx, input logic [31:0] data,
                                input logic last, input logic done);
        row_t r;
        r.busy = busy; r.rd_en = rd_en; r.rd_addr = addr; r.valid = valid;
        r.idx = idx; r.data = data; r.last = last; r.done = done;
        return r;
    endfunction

    // Results of the most recent DUT A run
    int          a_idx[$];
    logic [31:0] a_data[$];
    int          a_last_cyc, a_done_cyc, a_done_cnt, a_maxout, a_hold_bad;

    // mode 0: out_ready held high; mode 1: out_ready low in cycles 3..8
    task automatic run_a(input bit do_start, input int restart_cyc, input int end_cyc,
                         input int mode, input bit use_table);
        int cyc = 0;
        int issued = 0;
        int accepted = 0;
        logic [63:0] act, exp;
        a_idx.delete(); a_data.delete();
        a_last_cyc = -1; a_done_cyc = -1; a_done_cnt = 0; a_maxout = 0; a_hold_bad = 0;
        if (do_start) begin
            @(posedge clk); #1;
            ifa.start = 1'b1;
            ifa.out_ready = 1'b1;
        end
        while (cyc < end_cyc) begin
            @(posedge clk); #1;
            cyc++;
            ifa.start = (cyc == restart_cyc);
            ifa.out_ready = !(mode == 1 && cyc >= 3 && cyc <= 8);
            @(negedge clk);
            if (issued - accepted > a_maxout) a_maxout = issued - accepted;
            if (use_table && cyc <= 12) begin
                act = {21'd0, ifa.busy, ifa.rd_en, ifa.rd_addr, ifa.out_valid, ifa.out_last,
                       ifa.done, ifa.out_index, ifa.out_data};
                exp = {21'd0, tbl[cyc].busy, tbl[cyc].rd_en, tbl[cyc].rd_addr, tbl[cyc].valid,
                       tbl[cyc].last, tbl[cyc].done, tbl[cyc].idx, tbl[cyc].data};
                if (!tbl[cyc].valid) begin
                    act[34:0] = '0;
                    exp[34:0] = '0;
                end
                check($sformatf("row_c%0d", cyc), act, exp);
            end
            if (mode == 1 && cyc >= 3 && cyc <= 8 &&
                (ifa.rd_en || !ifa.out_valid || ifa.out_index != 3'd0)) a_hold_bad++;
            if (ifa.rd_en) issued++;
            if (ifa.out_valid && ifa.out_ready) begin
                a_idx.push_back(int'(ifa.out_index));
                a_data.push_back(ifa.out_data);
                accepted++;
                if (ifa.out_last) a_last_cyc = cyc;
            end
            if (ifa.done) begin
                a_done_cnt++;
                a_done_cyc = cyc;
            end
        end
    endtask

    task automatic check_a_stream(input string tag);
        int errs = 0;
        for (int i = 0; i < a_idx.size(); i++)
            if (a_idx[i] != i || a_data[i] != 32'(bitrev(i, 3) * 16)) errs++;
        check({tag, "_count"}, 64'(a_idx.size()), 64'd8);
        check({tag, "_order"}, 64'(errs), 64'd0);
        check({tag, "_done_cnt"}, 64'(a_done_cnt), 64'd1);
        check({tag, "_maxout"}, 64'(a_maxout > 2), 64'd0);
    endtask

    initial begin
        tbl[1]  = mk(1, 1, 3'd0, 0, 3'd0, 32'd0,   0, 0);
        tbl[2]  = mk(1, 1, 3'd4, 0, 3'd0, 32'd0,   0, 0);
        tbl[3]  = mk(1, 1, 3'd2, 1, 3'd0, 32'd0,   0, 0);
        tbl[4]  = mk(1, 1, 3'd6, 1, 3'd1, 32'd64,  0, 0);
        tbl[5]  = mk(1, 1, 3'd1, 1, 3'd2, 32'd32,  0, 0);
        tbl[6]  = mk(1, 1, 3'd5, 1, 3'd3, 32'd96,  0, 0);
        tbl[7]  = mk(1, 1, 3'd3, 1, 3'd4, 32'd16,  0, 0);
        tbl[8]  = mk(1, 1, 3'd7, 1, 3'd5, 32'd80,  0, 0);
        tbl[9]  = mk(1, 0, 3'd0, 1, 3'd6, 32'd48,  0, 0);
        tbl[10] = mk(1, 0, 3'd0, 1, 3'd7, 32'd112, 1, 0);
        tbl[11] = mk(0, 0, 3'd0, 0, 3'd0, 32'd0,   0, 1);
        tbl[12] = mk(0, 0, 3'd0, 0, 3'd0, 32'd0,   0, 0);

        ifa.start = 1'b0; ifa.out_ready = 1'b1; ifa.rd_data = '0;
        ifb.start = 1'b0; ifb.out_ready = 1'b1; ifb.rd_data = '0;

        // Reset values before any clock edge
        #1;
        check("reset_a_outputs", 64'({ifa.busy, ifa.done, ifa.rd_en, ifa.rd_addr, ifa.out_valid,
                                      ifa.out_data, ifa.out_index, ifa.out_last}), 64'd0);
        check("reset_b_outputs", 64'({ifb.busy, ifb.done, ifb.rd_en, ifb.rd_addr, ifb.out_valid,
                                      ifb.out_data, ifb.out_index, ifb.out_last}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain stream, out_ready high
        run_a(1, -1, 14, 0, 1);
        check_a_stream("plain");
        check("plain_last_cyc", 64'(a_last_cyc), 64'd10);
        check("plain_done_cyc", 64'(a_done_cyc), 64'd11);

        // Backpressure in cycles 3..8
        run_a(1, -1, 30, 1, 0);
        check_a_stream("bp");
        check("bp_hold", 64'(a_hold_bad), 64'd0);

        // Second start mid-run is ignored
        run_a(1, 5, 14, 0, 1);
        check_a_stream("restart_busy");
        check("restart_busy_done_cyc", 64'(a_done_cyc), 64'd11);

        // Start in the done cycle launches a second full run
        run_a(1, 11, 11, 0, 1);
        check("chain_first_done_cyc", 64'(a_done_cyc), 64'd11);
        run_a(0, -1, 14, 0, 1);
        check_a_stream("chain_second");

        // Reset in the middle of a run
        run_a(1, -1, 6, 0, 0);
        check("pre_abort_valid", 64'(ifa.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", 64'({ifa.busy, ifa.done, ifa.rd_en, ifa.rd_addr, ifa.out_valid,
                                    ifa.out_data, ifa.out_index, ifa.out_last}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_idle", 64'({ifa.busy, ifa.out_valid}), 64'd0);
        run_a(1, -1, 14, 0, 1);
        check_a_stream("after_abort");

        // MSB=4 with random out_ready
        begin
            int cyc = 0;
            int issued = 0;
            int accepted = 0;
            int maxout = 0;
            int errs = 0;
            int last_bad = 0;
            int done_cnt = 0;
            int seen_done = -1;
            @(posedge clk); #1;
            ifb.start = 1'b1;
            while (cyc < 300 && (seen_done < 0 || cyc < seen_done + 3)) begin
                @(posedge clk); #1;
                cyc++;
                ifb.start = 1'b0;
                ifb.out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (issued - accepted > maxout) maxout = issued - accepted;
                if (ifb.rd_en) issued++;
                if (ifb.out_valid && ifb.out_ready) begin
                    if (int'(ifb.out_index) != accepted ||
                        ifb.out_data != 32'(bitrev(accepted, 4) * 16)) errs++;
                    if (ifb.out_last != (ifb.out_index == 4'd15)) last_bad++;
                    accepted++;
                end
                if (ifb.done) begin
                    done_cnt++;
                    seen_done = cyc;
                end
            end
            check("rand_timeout", 64'(seen_done < 0), 64'd0);
            check("rand_count", 64'(accepted), 64'd16);
            check("rand_order", 64'(errs), 64'd0);
            check("rand_last", 64'(last_bad), 64'd0);
            check("rand_maxout", 64'(maxout > 2), 64'd0);
            check("rand_done_cnt", 64'(done_cnt), 64'd1);
            check("rand_idle", 64'(ifb.busy), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
